// File: rtl/shared_mem_responder.sv
// Sequential shared data memory for four cores with a built-in single-grant arbiter.
// Optional SHMEM_RR_EN selects round-robin arbitration; the default build uses fixed priority (core 0 highest).
module shared_mem_responder #(
    parameter int NCORE = 4,
    parameter int AW    = 7,
    parameter int DW    = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NCORE-1:0]      req,
    input  logic [NCORE-1:0]      we,
    input  logic [NCORE*AW-1:0]   addr_bus,
    input  logic [NCORE*DW-1:0]   wdata_bus,
    output logic [DW-1:0]         rdata,
    output logic [NCORE-1:0]      ack,
    output logic [1:0]            grant_id,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [1:0]      rr_ptr;
    logic [1:0]      arb_base;
    logic [1:0]      winner;
    logic            any_req;

    logic            take_req;
    logic            do_access;
    logic            do_resp;

    logic [AW-1:0]   lat_addr;
    logic [DW-1:0]   lat_wdata;
    logic            lat_we;

    logic [DW-1:0]   mem [2**AW];

    // Search starts at arb_base and wraps; the lowest offset with a request wins.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        winner  = 2'd0;
        any_req = |req;
`ifdef SHMEM_RR_EN
        arb_base = rr_ptr;
`else
        arb_base = rr_ptr & 2'b00;
`endif
        for (int k = NCORE - 1; k >= 0; k--) begin
            if (req[arb_base + 2'(k)]) begin
                winner = arb_base + 2'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        take_req   = 1'b0;
        do_access  = 1'b0;
        do_resp    = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    take_req   = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                do_access  = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                do_resp    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr    <= 2'd0;
            grant_id  <= 2'd0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            rdata     <= '0;
            ack       <= '0;
        end else begin
            if (take_req) begin
                grant_id  <= winner;
                lat_addr  <= addr_bus[int'(winner)*AW +: AW];
                lat_wdata <= wdata_bus[int'(winner)*DW +: DW];
                lat_we    <= we[winner];
            end
            if (do_access) begin
                if (!lat_we) begin
                    rdata <= mem[lat_addr];
                end
                ack <= NCORE'(1) << grant_id;
            end
            if (do_resp) begin
                ack    <= '0;
                rr_ptr <= grant_id + 2'd1;
            end
        end
    end

    // NOTE: the storage array has no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (do_access && lat_we) begin
            mem[lat_addr] <= lat_wdata;
        end
    end

endmodule

// File: tb/tb_shared_mem_responder.sv
// Scoreboard bench for shared_mem_responder: a transaction-level model predicts each grant and
// its response; a monitor compares every ack against the queued expectation.
module tb_shared_mem_responder;

    localparam int NCORE = 4;
    localparam int AW    = 7;
    localparam int DW    = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NCORE-1:0]  req = '0;
    logic [NCORE-1:0]  we = '0;
    logic [AW-1:0]     core_addr [NCORE];
    logic [DW-1:0]     core_wdata [NCORE];
    logic [NCORE*AW-1:0] addr_bus;
    logic [NCORE*DW-1:0] wdata_bus;
    logic [DW-1:0]     rdata;
    logic [NCORE-1:0]  ack;
    logic [1:0]        grant_id;
    logic              busy;

    assign addr_bus  = {core_addr[3], core_addr[2], core_addr[1], core_addr[0]};
    assign wdata_bus = {core_wdata[3], core_wdata[2], core_wdata[1], core_wdata[0]};

    shared_mem_responder #(.NCORE(NCORE), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .we        (we),
        .addr_bus  (addr_bus),
        .wdata_bus (wdata_bus),
        .rdata     (rdata),
        .ack       (ack),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int          core;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t        exp_q [$];
    int          grant_log [$];
    logic [31:0] mdl_mem [128];
    logic [31:0] mdl_rdata = '0;
    int          mdl_wait = 0;
    int          mdl_rr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Arbitration rule stated directly: first requester scanning from the pointer, or lowest index.
    function automatic int pick(input logic [3:0] r, input int base);
`ifdef SHMEM_RR_EN
        for (int k = 0; k < NCORE; k++) begin
            if (r[(base + k) % NCORE]) return (base + k) % NCORE;
        end
`else
        for (int k = 0; k < NCORE; k++) begin
            if (r[k]) return k;
        end
`endif
        return -1;
    endfunction

    // Model: a sample instant every third edge while requests are present; each access is atomic.
    always @(posedge clk) begin : model
        int   w;
        exp_t e;
        cyc++;
        if (reset_n) begin
            if (mdl_wait > 0) begin
                mdl_wait--;
            end else if (req != 0) begin
                w      = pick(req, mdl_rr);
                e.core = w;
                e.due  = cyc + 1;
                if (we[w]) begin
                    mdl_mem[core_addr[w]] = core_wdata[w];
                    e.rdata = mdl_rdata;
                end else begin
                    e.rdata   = mdl_mem[core_addr[w]];
                    mdl_rdata = e.rdata;
                end
                exp_q.push_back(e);
                mdl_rr   = (w + 1) % NCORE;
                mdl_wait = 2;
            end
        end
    end

    always @(negedge reset_n) begin
        exp_q.delete();
        mdl_wait  = 0;
        mdl_rr    = 0;
        mdl_rdata = '0;
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        int   ai;
        if (reset_n) begin
            check("busy", busy, (mdl_wait != 0));
            if (ack != 0) begin
                ai = 0;
                for (int k = NCORE - 1; k >= 0; k--) if (ack[k]) ai = k;
                grant_log.push_back(ai);
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", ack, 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("ack_onehot core%0d", e.core), ack, 32'(1) << e.core);
                    check($sformatf("grant_id core%0d", e.core), grant_id, e.core);
                    check($sformatf("rdata core%0d", e.core), rdata, e.rdata);
                    check($sformatf("ack_cycle core%0d", e.core), cyc, e.due);
                end
            end else if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
                e = exp_q.pop_front();
                check($sformatf("ack_cycle core%0d", e.core), cyc, e.due);
            end
        end
    end

    task automatic do_access(input int c, input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, output logic [DW-1:0] rd);
        bit got = 0;
        rd = '0;
        @(negedge clk);
        core_addr[c]  = a;
        core_wdata[c] = d;
        we[c]         = w;
        req[c]        = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ack[c]) begin
                got = 1;
                rd  = rdata;
            end
        end
        req[c] = 1'b0;
        check($sformatf("ack_arrived core%0d", c), 32'(got), 1);
    endtask

    task automatic new_txn(input int c);
        we[c]         = 1'($urandom_range(0, 1));
        core_addr[c]  = AW'($urandom);
        core_wdata[c] = $urandom;
        req[c]        = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rd;
        int            n;
        int            cnt1;
        int            exp_all [5];
        int            exp_three [5];

        for (int c = 0; c < NCORE; c++) begin
            core_addr[c]  = '0;
            core_wdata[c] = '0;
        end

        repeat (3) @(negedge clk);
        check("reset rdata", rdata, 0);
        check("reset ack", ack, 0);
        check("reset grant_id", grant_id, 0);
        check("reset busy", busy, 0);
        reset_n = 1'b1;

        for (int a = 0; a < 128; a++) do_access(0, 1'b1, AW'(a), $urandom, rd);

        do_access(1, 1'b1, 7'h05, 32'hDEADBEEF, rd);
        do_access(1, 1'b0, 7'h05, 32'h0, rd);
        check("core1 read 0x05", rd, 32'hDEADBEEF);

        do_access(2, 1'b1, 7'h7F, 32'h12345678, rd);
        do_access(0, 1'b1, 7'h00, 32'hCAFEF00D, rd);
        do_access(2, 1'b0, 7'h7F, 32'h0, rd);
        check("core2 read 0x7F", rd, 32'h12345678);

        do_access(0, 1'b1, 7'h10, 32'hA5A5A5A5, rd);
        check("write ack keeps rdata", rd, 32'h12345678);
        do_access(0, 1'b0, 7'h10, 32'h0, rd);
        check("core0 read 0x10", rd, 32'hA5A5A5A5);

        // Reset pulsed while the core3 read is in ACCESS.
        @(negedge clk);
        core_addr[3] = 7'h05;
        we[3]        = 1'b0;
        req[3]       = 1'b1;
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("midreset ack", ack, 0);
        check("midreset rdata", rdata, 0);
        check("midreset busy", busy, 0);
        check("midreset grant_id", grant_id, 0);
        req[3] = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        do_access(3, 1'b0, 7'h05, 32'h0, rd);
        check("core3 reissued read", rd, 32'hDEADBEEF);

        // All four cores request continuously from reset.
`ifdef SHMEM_RR_EN
        exp_all   = '{0, 1, 2, 3, 0};
        exp_three = '{1, 2, 3, 1, 1};
`else
        exp_all   = '{0, 0, 0, 0, 0};
        exp_three = '{1, 1, 1, 2, 3};
`endif
        @(negedge clk);
        reset_n = 1'b0;
        for (int c = 0; c < NCORE; c++) begin
            core_addr[c] = AW'($urandom);
            we[c]        = 1'b0;
        end
        req = 4'b1111;
        grant_log.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 60 && n < 5; i++) begin
            @(negedge clk);
            if (ack != 0) n++;
        end
        req = 4'b0000;
        repeat (3) @(negedge clk);
        check("all-req grant count", grant_log.size(), 5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            check($sformatf("all-req grant[%0d]", i), grant_log[i], exp_all[i]);

        // Cores 1..3 contend; core1 leaves after its third ack, others after their first.
        grant_log.delete();
        for (int c = 1; c < NCORE; c++) core_addr[c] = AW'($urandom);
        req  = 4'b1110;
        cnt1 = 0;
        for (int i = 0; i < 100 && req != 0; i++) begin
            @(negedge clk);
            if (ack[1]) begin
                cnt1++;
                if (cnt1 == 3) req[1] = 1'b0;
            end
            if (ack[2]) req[2] = 1'b0;
            if (ack[3]) req[3] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("three-req grant count", grant_log.size(), 5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            check($sformatf("three-req grant[%0d]", i), grant_log[i], exp_three[i]);

        // Random traffic from all cores obeying the hold-until-ack rule.
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            for (int c = 0; c < NCORE; c++) begin
                if (req[c] && ack[c]) begin
                    if ($urandom_range(0, 1) == 1) new_txn(c);
                    else req[c] = 1'b0;
                end else if (!req[c] && $urandom_range(0, 2) == 0) begin
                    new_txn(c);
                end
            end
        end
        req = '0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
